// File: rtl/isp_stat_ae_zone.sv
// Zoned auto-exposure statistics: per-zone saturating luma sums with a double-buffered
// result bank, so firmware reads a stable frame while the next one accumulates.
module isp_stat_ae_zone #(
    parameter int unsigned BITS      = 8,
    parameter int unsigned WIDTH     = 1280,
    parameter int unsigned HEIGHT    = 960,
    parameter int unsigned ZONES_X   = 4,
    parameter int unsigned ZONES_Y   = 4,
    parameter int unsigned STAT_BITS = 28,
    localparam int unsigned ZA = (ZONES_X * ZONES_Y > 1) ? $clog2(ZONES_X * ZONES_Y) : 1
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 in_href,
    input  logic                 in_vsync,
    input  logic [BITS-1:0]      in_y,
    input  logic                 stat_en,
    input  logic                 rd_en,
    input  logic [ZA-1:0]        rd_addr,
    output logic [STAT_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 frame_done,
    output logic                 stat_sat
);

    localparam int unsigned ZW  = WIDTH / ZONES_X;
    localparam int unsigned ZH  = HEIGHT / ZONES_Y;
    localparam int unsigned NZ  = ZONES_X * ZONES_Y;
    localparam int unsigned SW  = STAT_BITS + 1;
    localparam int unsigned CW  = $clog2(WIDTH + 1);
    localparam int unsigned RW  = $clog2(HEIGHT + 1);
    localparam int unsigned ZCW = $clog2(ZW + 1);
    localparam int unsigned ZRW = $clog2(ZH + 1);
    localparam int unsigned XW  = $clog2(ZONES_X + 1);
    localparam int unsigned YW  = $clog2(ZONES_Y + 1);

    if (ZONES_X < 1 || ZONES_Y < 1) begin : g_chk_zones
        $error("ZONES_X and ZONES_Y must be at least 1");
    end
    if (WIDTH % ZONES_X != 0) begin : g_chk_width
        $error("WIDTH must be divisible by ZONES_X");
    end
    if (HEIGHT % ZONES_Y != 0) begin : g_chk_height
        $error("HEIGHT must be divisible by ZONES_Y");
    end
    if (STAT_BITS <= BITS) begin : g_chk_stat
        $error("STAT_BITS must exceed BITS");
    end

    typedef enum logic [1:0] {StIdle, StActive, StCommit} state_e;

    state_e               state_q, state_d;
    logic                 pending_q, pending_d;
    logic                 vsync_q, href_q;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [ZCW-1:0]       zcol_q, zcol_d;
    logic [ZRW-1:0]       zrow_q, zrow_d;
    logic [XW-1:0]        zx_q, zx_d;
    logic [YW-1:0]        zy_q, zy_d;
    logic [STAT_BITS-1:0] work_q [NZ];
    logic [STAT_BITS-1:0] work_d [NZ];
    logic [STAT_BITS-1:0] shadow_q [NZ];
    logic [STAT_BITS-1:0] shadow_d [NZ];
    logic [NZ-1:0]        sat_q, sat_d;
    logic [STAT_BITS-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic                 stat_sat_q, stat_sat_d;

    logic                 rise, href_fall, accept, clear;
    logic [STAT_BITS:0]   sum;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        col_d        = col_q;
        row_d        = row_q;
        zcol_d       = zcol_q;
        zrow_d       = zrow_q;
        zx_d         = zx_q;
        zy_d         = zy_q;
        work_d       = work_q;
        shadow_d     = shadow_q;
        sat_d        = sat_q;
        stat_sat_d   = stat_sat_q;
        frame_done_d = 1'b0;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_en;
        accept       = 1'b0;
        clear        = 1'b0;
        sum          = '0;
        rise         = in_vsync & ~vsync_q;
        href_fall    = href_q & ~in_href;

        unique case (state_q)
            StIdle: begin
                // A rise caught during commit is serviced here as if it had just arrived.
                if (rise || pending_q) begin
                    pending_d = 1'b0;
                    if (stat_en) begin
                        state_d = StActive;
                        clear   = 1'b1;
                    end
                end
            end
            StActive: begin
                if (rise) begin
                    if (stat_en) begin
                        clear = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (in_href && col_q < CW'(WIDTH) && row_q < RW'(HEIGHT)) begin
                        accept = 1'b1;
                        col_d  = col_q + CW'(1);
                        if (zcol_q == ZCW'(ZW - 1)) begin
                            zcol_d = '0;
                            zx_d   = zx_q + XW'(1);
                        end else begin
                            zcol_d = zcol_q + ZCW'(1);
                        end
                    end
                    if (href_fall && row_q < RW'(HEIGHT)) begin
                        col_d  = '0;
                        zcol_d = '0;
                        zx_d   = '0;
                        row_d  = row_q + RW'(1);
                        if (zrow_q == ZRW'(ZH - 1)) begin
                            zrow_d = '0;
                            zy_d   = zy_q + YW'(1);
                        end else begin
                            zrow_d = zrow_q + ZRW'(1);
                        end
                        if (row_q == RW'(HEIGHT - 1)) begin
                            state_d = StCommit;
                        end
                    end
                end
            end
            StCommit: begin
                shadow_d     = work_q;
                stat_sat_d   = |sat_q;
                frame_done_d = 1'b1;
                state_d      = StIdle;
                if (rise) begin
                    pending_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        for (int z = 0; z < NZ; z++) begin
            if (accept && zy_q == YW'(z / ZONES_X) && zx_q == XW'(z % ZONES_X)) begin
                sum = {1'b0, work_q[z]} + SW'(in_y);
                if (sum[STAT_BITS]) begin
                    work_d[z] = '1;
                    sat_d[z]  = 1'b1;
                end else begin
                    work_d[z] = sum[STAT_BITS-1:0];
                end
            end
        end

        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            zcol_d = '0;
            zrow_d = '0;
            zx_d   = '0;
            zy_d   = '0;
            sat_d  = '0;
            for (int z = 0; z < NZ; z++) begin
                work_d[z] = '0;
            end
        end

        // Out-of-range addresses match no zone and read back as zero.
        if (rd_en) begin
            rd_data_d = '0;
            for (int z = 0; z < NZ; z++) begin
                if (rd_addr == ZA'(z)) begin
                    rd_data_d = shadow_q[z];
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pending_q    <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            zcol_q       <= '0;
            zrow_q       <= '0;
            zx_q         <= '0;
            zy_q         <= '0;
            sat_q        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            stat_sat_q   <= 1'b0;
            for (int z = 0; z < NZ; z++) begin
                work_q[z]   <= '0;
                shadow_q[z] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            vsync_q      <= in_vsync;
            href_q       <= in_href;
            col_q        <= col_d;
            row_q        <= row_d;
            zcol_q       <= zcol_d;
            zrow_q       <= zrow_d;
            zx_q         <= zx_d;
            zy_q         <= zy_d;
            sat_q        <= sat_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            frame_done_q <= frame_done_d;
            stat_sat_q   <= stat_sat_d;
            work_q       <= work_d;
            shadow_q     <= shadow_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign frame_done = frame_done_q;
    assign stat_sat   = stat_sat_q;

endmodule

// File: tb/tb_isp_stat_ae_zone.sv
// Directed bench for isp_stat_ae_zone: three instances share stimulus (2x2/12-bit main,
// 2x2/10-bit for saturation, 3x1 so an out-of-range zone address is representable).
module tb_isp_stat_ae_zone;

    logic       pclk     = 1'b0;
    logic       rst_n    = 1'b1;
    logic       in_href  = 1'b0;
    logic       in_vsync = 1'b0;
    logic [7:0] in_y     = 8'd0;
    logic       stat_en  = 1'b0;
    logic       rd_en    = 1'b0;
    logic [1:0] rd_addr  = 2'd0;

    logic [11:0] rd_data_a;
    logic        rd_valid_a, frame_done_a, stat_sat_a;
    logic [9:0]  rd_data_b;
    logic        rd_valid_b, frame_done_b, stat_sat_b;
    logic [11:0] rd_data_c;
    logic        rd_valid_c, frame_done_c, stat_sat_c;

    int n_run  = 0;
    int n_fail = 0;
    int done_a = 0;
    int done_b = 0;

    isp_stat_ae_zone #(
        .BITS(8), .WIDTH(8), .HEIGHT(4), .ZONES_X(2), .ZONES_Y(2), .STAT_BITS(12)
    ) dut_a (
        .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync), .in_y(in_y),
        .stat_en(stat_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .frame_done(frame_done_a), .stat_sat(stat_sat_a)
    );

    isp_stat_ae_zone #(
        .BITS(8), .WIDTH(8), .HEIGHT(4), .ZONES_X(2), .ZONES_Y(2), .STAT_BITS(10)
    ) dut_b (
        .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync), .in_y(in_y),
        .stat_en(stat_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .frame_done(frame_done_b), .stat_sat(stat_sat_b)
    );

    isp_stat_ae_zone #(
        .BITS(8), .WIDTH(6), .HEIGHT(4), .ZONES_X(3), .ZONES_Y(1), .STAT_BITS(12)
    ) dut_c (
        .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync), .in_y(in_y),
        .stat_en(stat_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c),
        .rd_valid(rd_valid_c), .frame_done(frame_done_c), .stat_sat(stat_sat_c)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (frame_done_a) done_a++;
        if (frame_done_b) done_b++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // mode 0: constant, 1: quadrants 1/2/3/4, 2: cols 8+ are 255, others 10
    function automatic logic [7:0] pix(input int mode, input int val, input int c, input int r);
        if (mode == 1) return (r < 2) ? ((c < 4) ? 8'd1 : 8'd2) : ((c < 4) ? 8'd3 : 8'd4);
        if (mode == 2) return (c >= 8) ? 8'd255 : 8'd10;
        return 8'(val);
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic frame_start();
        tick(); in_vsync = 1'b1;
        tick(); tick(); in_vsync = 1'b0;
        tick(); tick();
    endtask

    task automatic send_line(input int r, input int npix, input int mode, input int val);
        for (int c = 0; c < npix; c++) begin
            tick(); in_href = 1'b1; in_y = pix(mode, val, c, r);
        end
        tick(); in_href = 1'b0; in_y = 8'd0;
    endtask

    task automatic send_lines(input int nl, input int npix, input int mode, input int val);
        for (int r = 0; r < nl; r++) begin
            send_line(r, npix, mode, val);
            if (r != nl - 1) begin
                tick(); tick();
            end
        end
    endtask

    task automatic frame(input int mode, input int val, input int npix);
        frame_start();
        send_lines(4, npix, mode, val);
        repeat (6) tick();
    endtask

    task automatic rd(input logic [1:0] a);
        tick(); rd_en = 1'b1; rd_addr = a;
        tick(); rd_en = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_run++;
        if ({rd_data_a, rd_valid_a, frame_done_a, stat_sat_a} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_a: got data=%0d valid=%b done=%b sat=%b, want all 0",
                     rd_data_a, rd_valid_a, frame_done_a, stat_sat_a);
        end
        n_run++;
        if ({rd_data_b, rd_valid_b, rd_data_c, rd_valid_c} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_bc: got b=%0d/%b c=%0d/%b, want all 0",
                     rd_data_b, rd_valid_b, rd_data_c, rd_valid_c);
        end
        rd_en = 1'b1;
        tick(); tick();
        n_run++;
        if (rd_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_valid: got %b, want 0", rd_valid_a);
        end
        rd_en = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        int d0;
        d0 = done_a;
        stat_en = 1'b1;
        frame(0, 10, 8);
        n_run++;
        if (done_a - d0 !== 1) begin
            n_fail++;
            $display("FAIL t1_done_pulses: got %0d, want 1", done_a - d0);
        end
        for (int z = 0; z < 4; z++) begin
            rd(2'(z));
            n_run++;
            if (rd_valid_a !== 1'b1 || rd_data_a !== 12'd80) begin
                n_fail++;
                $display("FAIL t1_zone%0d: got valid=%b data=%0d, want valid=1 data=80",
                         z, rd_valid_a, rd_data_a);
            end
        end
        tick();
        n_run++;
        if (rd_valid_a !== 1'b0 || rd_data_a !== 12'd80) begin
            n_fail++;
            $display("FAIL t1_idle_hold: got valid=%b data=%0d, want valid=0 data=80",
                     rd_valid_a, rd_data_a);
        end
        n_run++;
        if (stat_sat_a !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_sat: got %b, want 0", stat_sat_a);
        end
    endtask

    task automatic test_quadrants();
        int exp_q[4] = '{8, 16, 24, 32};
        frame(1, 0, 8);
        for (int z = 0; z < 4; z++) begin
            rd(2'(z));
            n_run++;
            if (rd_valid_a !== 1'b1 || rd_data_a !== 12'(exp_q[z])) begin
                n_fail++;
                $display("FAIL t2_quad%0d: got valid=%b data=%0d, want valid=1 data=%0d",
                         z, rd_valid_a, rd_data_a, exp_q[z]);
            end
        end
        frame(0, 0, 8);
        for (int z = 0; z < 4; z++) begin
            rd(2'(z));
            n_run++;
            if (rd_data_a !== 12'd0) begin
                n_fail++;
                $display("FAIL t2_zero%0d: got %0d, want 0", z, rd_data_a);
            end
        end
    endtask

    task automatic test_saturation();
        frame(0, 255, 8);
        for (int z = 0; z < 4; z++) begin
            rd(2'(z));
            n_run++;
            if (rd_data_b !== 10'd1023 || rd_data_a !== 12'd2040) begin
                n_fail++;
                $display("FAIL t3_sat_zone%0d: got b=%0d a=%0d, want b=1023 a=2040",
                         z, rd_data_b, rd_data_a);
            end
        end
        n_run++;
        if (stat_sat_b !== 1'b1 || stat_sat_a !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_sat_flag: got b=%b a=%b, want b=1 a=0", stat_sat_b, stat_sat_a);
        end
        frame(0, 1, 8);
        for (int z = 0; z < 4; z++) begin
            rd(2'(z));
            n_run++;
            if (rd_data_b !== 10'd8) begin
                n_fail++;
                $display("FAIL t3_recover_zone%0d: got %0d, want 8", z, rd_data_b);
            end
        end
        n_run++;
        if (stat_sat_b !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_sat_clear: got %b, want 0", stat_sat_b);
        end
    endtask

    task automatic test_short_frame();
        int d0;
        frame(0, 10, 8);
        d0 = done_a;
        frame_start();
        send_lines(2, 8, 0, 10);
        repeat (3) tick();
        n_run++;
        if (done_a !== d0) begin
            n_fail++;
            $display("FAIL t4_no_done: got %0d pulses, want 0", done_a - d0);
        end
        for (int z = 0; z < 4; z++) begin
            rd(2'(z));
            n_run++;
            if (rd_data_a !== 12'd80) begin
                n_fail++;
                $display("FAIL t4_hold_zone%0d: got %0d, want 80", z, rd_data_a);
            end
        end
        frame(0, 5, 8);
        n_run++;
        if (done_a - d0 !== 1) begin
            n_fail++;
            $display("FAIL t4_restart_done: got %0d pulses, want 1", done_a - d0);
        end
        for (int z = 0; z < 4; z++) begin
            rd(2'(z));
            n_run++;
            if (rd_data_a !== 12'd40) begin
                n_fail++;
                $display("FAIL t4_restart_zone%0d: got %0d, want 40", z, rd_data_a);
            end
        end
    endtask

    task automatic test_long_lines();
        frame(2, 0, 10);
        for (int z = 0; z < 4; z++) begin
            rd(2'(z));
            n_run++;
            if (rd_data_a !== 12'd80) begin
                n_fail++;
                $display("FAIL t5_clip_zone%0d: got %0d, want 80", z, rd_data_a);
            end
        end
        for (int z = 0; z < 3; z++) begin
            rd(2'(z));
            n_run++;
            if (rd_data_c !== 12'd80) begin
                n_fail++;
                $display("FAIL t5_c_zone%0d: got %0d, want 80", z, rd_data_c);
            end
        end
        // zone 3 does not exist in the 3-zone instance
        rd(2'd3);
        n_run++;
        if (rd_valid_c !== 1'b1 || rd_data_c !== 12'd0 || rd_data_a !== 12'd80) begin
            n_fail++;
            $display("FAIL t5_oob: got c=%b/%0d a=%0d, want c=1/0 a=80",
                     rd_valid_c, rd_data_c, rd_data_a);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        int exp_q[4] = '{8, 16, 24, 32};
        d0 = done_a;
        frame_start();
        send_lines(4, 8, 0, 2);
        // FSM is in COMMIT for the next edge: read and raise vsync then
        tick(); in_vsync = 1'b1; rd_en = 1'b1; rd_addr = 2'd0;
        tick(); rd_en = 1'b0;
        n_run++;
        if (rd_valid_a !== 1'b1 || rd_data_a !== 12'd80) begin
            n_fail++;
            $display("FAIL commit_read: got valid=%b data=%0d, want valid=1 data=80",
                     rd_valid_a, rd_data_a);
        end
        n_run++;
        if (frame_done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL commit_pulse: got %b, want 1", frame_done_a);
        end
        tick(); tick(); in_vsync = 1'b0;
        rd(2'd0);
        n_run++;
        if (rd_data_a !== 12'd16) begin
            n_fail++;
            $display("FAIL post_commit_read: got %0d, want 16", rd_data_a);
        end
        send_lines(4, 8, 1, 0);
        repeat (6) tick();
        n_run++;
        if (done_a - d0 !== 2) begin
            n_fail++;
            $display("FAIL pending_frame_done: got %0d pulses, want 2", done_a - d0);
        end
        tick(); rd_en = 1'b1; rd_addr = 2'd0;
        for (int z = 1; z <= 4; z++) begin
            tick();
            if (z < 4) rd_addr = 2'(z);
            else rd_en = 1'b0;
            n_run++;
            if (rd_valid_a !== 1'b1 || rd_data_a !== 12'(exp_q[z-1])) begin
                n_fail++;
                $display("FAIL b2b_zone%0d: got valid=%b data=%0d, want valid=1 data=%0d",
                         z - 1, rd_valid_a, rd_data_a, exp_q[z-1]);
            end
        end
    endtask

    task automatic test_disable_and_reset();
        int d0;
        d0 = done_a;
        stat_en = 1'b0;
        frame(0, 7, 8);
        n_run++;
        if (done_a !== d0) begin
            n_fail++;
            $display("FAIL t6_disabled_done: got %0d pulses, want 0", done_a - d0);
        end
        rd(2'd1);
        n_run++;
        if (rd_data_a !== 12'd16) begin
            n_fail++;
            $display("FAIL t6_disabled_shadow: got %0d, want 16", rd_data_a);
        end
        stat_en = 1'b1;
        frame_start();
        send_lines(2, 8, 0, 9);
        tick(); rst_n = 1'b0;
        #1;
        n_run++;
        if ({rd_data_a, rd_valid_a, frame_done_a, stat_sat_a} !== 15'd0) begin
            n_fail++;
            $display("FAIL t6_midreset_out: got data=%0d valid=%b done=%b sat=%b, want all 0",
                     rd_data_a, rd_valid_a, frame_done_a, stat_sat_a);
        end
        tick(); tick(); rst_n = 1'b1;
        for (int z = 0; z < 4; z++) begin
            rd(2'(z));
            n_run++;
            if (rd_data_a !== 12'd0) begin
                n_fail++;
                $display("FAIL t6_reset_zone%0d: got %0d, want 0", z, rd_data_a);
            end
        end
        d0 = done_a;
        frame(0, 3, 8);
        n_run++;
        if (done_a - d0 !== 1) begin
            n_fail++;
            $display("FAIL t6_after_reset_done: got %0d pulses, want 1", done_a - d0);
        end
        for (int z = 0; z < 4; z++) begin
            rd(2'(z));
            n_run++;
            if (rd_data_a !== 12'd24) begin
                n_fail++;
                $display("FAIL t6_after_reset_zone%0d: got %0d, want 24", z, rd_data_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_quadrants();
        test_saturation();
        test_short_frame();
        test_long_lines();
        test_back_to_back();
        test_disable_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
